// File: rtl/pipeline_regfile_pkg.sv
// Shared widths and address/data types for the pipeline register file.
// Purely declarative: no logic, no latency, no flow control.
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/pipeline_regfile_if.sv
// Decode/writeback bundle of the register file: two read ports, one write port, issue and flush.
// Master drives addresses and commands; slave returns combinational data and busy flags.
interface pipeline_regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] read_addr_a;
  logic [ADDR_WIDTH-1:0] read_addr_b;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_address;
  logic                  flush;
  logic                  busy_a;
  logic                  busy_b;

  modport master (
    output read_addr_a, read_addr_b, write_address, write_data, reg_write,
    output issue_valid, issue_address, flush,
    input  data_a, data_b, busy_a, busy_b
  );

  modport slave (
    input  read_addr_a, read_addr_b, write_address, write_data, reg_write,
    input  issue_valid, issue_address, flush,
    output data_a, data_b, busy_a, busy_b
  );
endinterface

// File: rtl/pipeline_regfile_scoreboard.sv
// Pending-write scoreboard: flush > issue > writeback at each edge; busy lookup is combinational.
// Issue/flush take effect after one edge; a bypassed writeback hides busy in its own cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_issue_valid,
  input  logic [ADDR_WIDTH-1:0] i_issue_address,
  input  logic                  i_reg_write,
  input  logic [ADDR_WIDTH-1:0] i_write_address,
  input  logic [ADDR_WIDTH-1:0] i_read_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_read_addr_b,
  output logic                  o_busy_a,
  output logic                  o_busy_b
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_nxt;
  logic             w_issue_en;

  assign w_issue_en = i_issue_valid && !((ZERO_REG != 0) && (i_issue_address == '0));

  // Issue is applied after writeback so a new producer keeps the register busy.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_flush) begin
      w_pending_nxt = '0;
    end else begin
      if (i_reg_write) w_pending_nxt[i_write_address] = 1'b0;
      if (w_issue_en)  w_pending_nxt[i_issue_address] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  function automatic logic busy_lookup(input logic [ADDR_WIDTH-1:0] addr);
    logic b;
    b = r_pending[addr];
    if ((ZERO_REG != 0) && (addr == '0)) b = 1'b0;
    if ((BYPASS != 0) && i_reg_write && (i_write_address == addr)) b = 1'b0;
    return b;
  endfunction

  assign o_busy_a = busy_lookup(i_read_addr_a);
  assign o_busy_b = busy_lookup(i_read_addr_b);
endmodule

// File: rtl/pipeline_regfile.sv
// Two-read/one-write register file with same-cycle bypass, optional zero register and RAW scoreboard.
// Writes land on one edge; reads and busy are combinational; no backpressure.
module pipeline_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
)(
  input logic                clk,
  input logic                rst_n,
  pipeline_regfile_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_wr_en;
  logic                  w_byp_en;
  logic [DATA_WIDTH-1:0] w_data_a;
  logic [DATA_WIDTH-1:0] w_data_b;

  assign w_wr_en  = bus.reg_write && !((ZERO_REG != 0) && (bus.write_address == '0));
  // Forwarding is suppressed during reset so outputs read as zero immediately.
  assign w_byp_en = (BYPASS != 0) && rst_n && bus.reg_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.write_address] <= bus.write_data;
    end
  end

  always_comb begin
    w_data_a = r_mem[bus.read_addr_a];
    if (w_byp_en && (bus.write_address == bus.read_addr_a)) w_data_a = bus.write_data;
    if ((ZERO_REG != 0) && (bus.read_addr_a == '0))         w_data_a = '0;
  end

  always_comb begin
    w_data_b = r_mem[bus.read_addr_b];
    if (w_byp_en && (bus.write_address == bus.read_addr_b)) w_data_b = bus.write_data;
    if ((ZERO_REG != 0) && (bus.read_addr_b == '0))         w_data_b = '0;
  end

  assign bus.data_a = w_data_a;
  assign bus.data_b = w_data_b;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_flush         (bus.flush),
    .i_issue_valid   (bus.issue_valid),
    .i_issue_address (bus.issue_address),
    .i_reg_write     (bus.reg_write),
    .i_write_address (bus.write_address),
    .i_read_addr_a   (bus.read_addr_a),
    .i_read_addr_b   (bus.read_addr_b),
    .o_busy_a        (bus.busy_a),
    .o_busy_b        (bus.busy_b)
  );
endmodule

// File: tb/tb_pipeline_regfile.sv
// Directed bench for pipeline_regfile: a BYPASS=1 and a BYPASS=0 instance share identical stimulus.
module tb_pipeline_regfile;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pipeline_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf1_if ();
  pipeline_regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf0_if ();

  pipeline_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk (clk), .rst_n (rst_n), .bus (rf1_if.slave)
  );
  pipeline_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) dut_nobyp (
    .clk (clk), .rst_n (rst_n), .bus (rf0_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rf1_if.reg_write = 1'b0; rf0_if.reg_write = 1'b0;
    rf1_if.issue_valid = 1'b0; rf0_if.issue_valid = 1'b0;
    rf1_if.flush = 1'b0; rf0_if.flush = 1'b0;
    rf1_if.write_address = '0; rf0_if.write_address = '0;
    rf1_if.write_data = '0; rf0_if.write_data = '0;
    rf1_if.issue_address = '0; rf0_if.issue_address = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input reg_addr_t a, input reg_addr_t b);
    rf1_if.read_addr_a = a; rf0_if.read_addr_a = a;
    rf1_if.read_addr_b = b; rf0_if.read_addr_b = b;
    #1;
  endtask

  task automatic set_wr(input reg_addr_t a, input reg_data_t d);
    rf1_if.reg_write = 1'b1; rf0_if.reg_write = 1'b1;
    rf1_if.write_address = a; rf0_if.write_address = a;
    rf1_if.write_data = d; rf0_if.write_data = d;
  endtask

  task automatic set_issue(input reg_addr_t a);
    rf1_if.issue_valid = 1'b1; rf0_if.issue_valid = 1'b1;
    rf1_if.issue_address = a; rf0_if.issue_address = a;
  endtask

  task automatic do_write(input reg_addr_t a, input reg_data_t d);
    set_wr(a, d);
    tick();
    idle();
  endtask

  task automatic do_issue(input reg_addr_t a);
    set_issue(a);
    tick();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle();
    set_rd(5'd3, 5'd4);
    repeat (3) tick();

    check("reset data_a", rf1_if.data_a, 32'h0);
    check("reset data_b", rf1_if.data_b, 32'h0);
    check("reset busy_a", {31'b0, rf1_if.busy_a}, 32'h0);
    check("reset busy_b", {31'b0, rf1_if.busy_b}, 32'h0);

    rst_n = 1'b1;
    tick();

    for (int i = 1; i < 32; i++) do_write(reg_addr_t'(i), reg_data_t'(i));
    set_rd(5'd14, 5'd17);
    check("fill a14", rf1_if.data_a, 32'd14);
    check("fill b17", rf1_if.data_b, 32'd17);
    set_rd(5'd20, 5'd31);
    check("fill a20", rf1_if.data_a, 32'd20);
    check("fill b31", rf1_if.data_b, 32'd31);
    check("fill nobyp b31", rf0_if.data_b, 32'd31);
    set_rd(5'd0, 5'd15);
    check("fill a0", rf1_if.data_a, 32'd0);
    check("fill b15", rf1_if.data_b, 32'd15);

    // Zero register: dropped write, and no forwarding to address 0 either.
    set_rd(5'd0, 5'd0);
    set_wr(5'd0, 32'hDEADBEEF);
    #1;
    check("zero write same cycle", rf1_if.data_a, 32'h0);
    tick();
    idle();
    #1;
    check("zero after write", rf1_if.data_a, 32'h0);
    check("zero busy_a", {31'b0, rf1_if.busy_a}, 32'h0);
    do_issue(5'd0);
    #1;
    check("zero issue busy", {31'b0, rf1_if.busy_a}, 32'h0);

    // Bypass vs no bypass.
    set_rd(5'd9, 5'd9);
    set_wr(5'd9, 32'h12345678);
    #1;
    check("bypass data_a", rf1_if.data_a, 32'h12345678);
    check("bypass data_b", rf1_if.data_b, 32'h12345678);
    check("nobyp old data_a", rf0_if.data_a, 32'd9);
    tick();
    idle();
    #1;
    check("nobyp new data_a", rf0_if.data_a, 32'h12345678);

    // Scoreboard.
    set_rd(5'd7, 5'd8);
    do_issue(5'd7);
    #1;
    check("issue7 busy", {31'b0, rf1_if.busy_a}, 32'h1);
    check("issue7 nobyp busy", {31'b0, rf0_if.busy_a}, 32'h1);
    set_wr(5'd7, 32'h77);
    #1;
    check("wb7 bypass busy", {31'b0, rf1_if.busy_a}, 32'h0);
    check("wb7 nobyp busy", {31'b0, rf0_if.busy_a}, 32'h1);
    tick();
    idle();
    #1;
    check("wb7 after busy", {31'b0, rf1_if.busy_a}, 32'h0);
    check("wb7 nobyp after busy", {31'b0, rf0_if.busy_a}, 32'h0);
    check("wb7 data", rf0_if.data_a, 32'h77);
    set_issue(5'd7);
    set_wr(5'd7, 32'h70);
    tick();
    idle();
    #1;
    check("issue+wb7 busy", {31'b0, rf1_if.busy_a}, 32'h1);
    check("issue+wb7 data", rf1_if.data_a, 32'h70);
    set_issue(5'd8);
    set_wr(5'd7, 32'h71);
    tick();
    idle();
    #1;
    check("split wb7 busy", {31'b0, rf1_if.busy_a}, 32'h0);
    check("split issue8 busy", {31'b0, rf1_if.busy_b}, 32'h1);

    // Flush with simultaneous issue.
    do_issue(5'd3);
    do_issue(5'd4);
    do_issue(5'd5);
    set_rd(5'd3, 5'd5);
    check("pend3 busy", {31'b0, rf1_if.busy_a}, 32'h1);
    check("pend5 busy", {31'b0, rf1_if.busy_b}, 32'h1);
    rf1_if.flush = 1'b1; rf0_if.flush = 1'b1;
    set_issue(5'd6);
    tick();
    idle();
    set_rd(5'd3, 5'd4);
    check("flush busy3", {31'b0, rf1_if.busy_a}, 32'h0);
    check("flush busy4", {31'b0, rf1_if.busy_b}, 32'h0);
    check("flush data3", rf1_if.data_a, 32'd3);
    check("flush data4", rf1_if.data_b, 32'd4);
    set_rd(5'd5, 5'd6);
    check("flush busy5", {31'b0, rf1_if.busy_a}, 32'h0);
    check("flush busy6", {31'b0, rf1_if.busy_b}, 32'h0);
    check("flush data5", rf1_if.data_a, 32'd5);
    check("flush data6", rf1_if.data_b, 32'd6);
    set_rd(5'd8, 5'd8);
    check("flush busy8", {31'b0, rf1_if.busy_a}, 32'h0);

    // Asynchronous reset between edges.
    do_issue(5'd2);
    set_rd(5'd2, 5'd31);
    check("pre-rst busy2", {31'b0, rf1_if.busy_a}, 32'h1);
    check("pre-rst data31", rf1_if.data_b, 32'd31);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst data_a", rf1_if.data_a, 32'h0);
    check("arst data_b", rf1_if.data_b, 32'h0);
    check("arst busy_a", {31'b0, rf1_if.busy_a}, 32'h0);
    check("arst busy_b", {31'b0, rf1_if.busy_b}, 32'h0);
    #2;
    rst_n = 1'b1;
    set_rd(5'd2, 5'd2);
    set_wr(5'd2, 32'd5);
    #1;
    check("post-rst nobyp old", rf0_if.data_a, 32'h0);
    tick();
    idle();
    #1;
    check("post-rst write2", rf1_if.data_a, 32'd5);
    check("post-rst nobyp write2", rf0_if.data_b, 32'd5);
    check("post-rst busy2", {31'b0, rf1_if.busy_a}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
